// File: rtl/rcu_pkg.sv
// Shared constants and tag type for the rename physical-register allocator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rcu_pkg;

  localparam int PREG_WIDTH        = 5;  // physical register tag width, same as free-list data
  localparam int STAGE_DEPTH       = 4;  // staging entries, power of two, >= 2
  localparam int STAGE_DEPTH_WIDTH = 2;  // log2(STAGE_DEPTH)

  typedef logic [PREG_WIDTH-1:0] preg_t;

endpackage

// File: rtl/rcu_preg_stage_buf.sv
// Two-write / two-read circular staging buffer for free physical register tags.
// Latency: a tag written at an edge is visible on rd_dat0/rd_dat1 right after that edge.
// Backpressure: none internally; the caller never writes past full or reads past count.
//
// Ports: clk/rst (async active-low), clr (synchronous pointer clear),
//        wr_cnt + wr_dat0/1 (0..2 tags appended at tail),
//        rd_cnt (0..2 tags retired from head), rd_dat0/1 (entries at head, head+1),
//        count (occupied entries, one bit wider than the pointers).
module rcu_preg_stage_buf
  import rcu_pkg::*;
#(
  parameter int DEPTH = STAGE_DEPTH,
  parameter int PW    = STAGE_DEPTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [1:0]            wr_cnt,
  input  logic [PREG_WIDTH-1:0] wr_dat0,
  input  logic [PREG_WIDTH-1:0] wr_dat1,
  input  logic [1:0]            rd_cnt,
  output logic [PREG_WIDTH-1:0] rd_dat0,
  output logic [PREG_WIDTH-1:0] rd_dat1,
  output logic [PW:0]           count
);

  localparam int CW = PW + 1;

  preg_t         mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      // Staged tags are simply abandoned; the free list rewinds on its own.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_cnt != 2'd0) begin
        mem[tail] <= wr_dat0;
      end
      if (wr_cnt == 2'd2) begin
        mem[tail + PW'(1)] <= wr_dat1;
      end
      tail  <= tail + PW'(wr_cnt);
      head  <= head + PW'(rd_cnt);
      count <= count - CW'(rd_cnt) + CW'(wr_cnt);
    end
  end

  assign rd_dat0 = mem[head];
  assign rd_dat1 = mem[head + PW'(1)];

endmodule

// File: rtl/rcu_preg_alloc.sv
// Rename-stage allocator: stages free-list tags and serves up to two rename lanes per cycle.
// Latency: a tag popped from the free list is offered to rename one cycle later.
// Backpressure: all-or-nothing; alloc_ready_o drops unless every asserted lane can be served.
//
// Ports: clk, rst (async active-low), flush_i (sync discard of staged tags),
//        req_first_i/req_second_i -> alloc_ready_o, alloc_prd_first_o/second_o,
//        fl_rd_first_en_o/fl_rd_second_en_o pop the free list, whose head data arrives on
//        fl_rdata_first_i/second_i with fl_empty_i/fl_almost_empty_i status,
//        stage_cnt_o reports occupancy.
// Optional: define PREG_ALLOC_STALL_CNT_EN to add stall_cnt_o, a 32-bit count of cycles
//        in which rename asked for tags and was refused.
module rcu_preg_alloc
  import rcu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         req_first_i,
  input  logic                         req_second_i,
  output logic                         alloc_ready_o,
  output logic [PREG_WIDTH-1:0]        alloc_prd_first_o,
  output logic [PREG_WIDTH-1:0]        alloc_prd_second_o,
  output logic                         fl_rd_first_en_o,
  output logic                         fl_rd_second_en_o,
  input  logic [PREG_WIDTH-1:0]        fl_rdata_first_i,
  input  logic [PREG_WIDTH-1:0]        fl_rdata_second_i,
  input  logic                         fl_empty_i,
  input  logic                         fl_almost_empty_i,
  output logic [STAGE_DEPTH_WIDTH:0]   stage_cnt_o
`ifdef PREG_ALLOC_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int             CW         = STAGE_DEPTH_WIDTH + 1;
  localparam logic [CW-1:0]  FULL_C     = CW'(STAGE_DEPTH);
  localparam logic [CW-1:0]  TWO_FREE_C = CW'(STAGE_DEPTH - 2);

  logic [CW-1:0] count;
  logic [CW-1:0] need;
  logic          grant;
  logic [1:0]    rd_cnt;
  logic [1:0]    wr_cnt;
  preg_t         head0;
  preg_t         head1;

  assign need = CW'(req_first_i) + CW'(req_second_i);

  // The handshake and pops are qualified with rst so every control output reads 0
  // the moment reset asserts, not only after the registers have cleared.
  assign alloc_ready_o = rst && !flush_i && (count >= need);
  assign grant         = alloc_ready_o && (need != '0);
  assign rd_cnt        = grant ? (2'(req_first_i) + 2'(req_second_i)) : 2'd0;

  // Refill looks only at registered occupancy so the rename request path never
  // reaches the free-list read enables.
  assign fl_rd_first_en_o  = rst && !flush_i && (count < FULL_C) && !fl_empty_i;
  assign fl_rd_second_en_o = fl_rd_first_en_o && (count <= TWO_FREE_C) && !fl_almost_empty_i;
  assign wr_cnt            = 2'(fl_rd_first_en_o) + 2'(fl_rd_second_en_o);

  rcu_preg_stage_buf #(
    .DEPTH (STAGE_DEPTH),
    .PW    (STAGE_DEPTH_WIDTH)
  ) u_stage_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_i),
    .wr_cnt  (wr_cnt),
    .wr_dat0 (fl_rdata_first_i),
    .wr_dat1 (fl_rdata_second_i),
    .rd_cnt  (rd_cnt),
    .rd_dat0 (head0),
    .rd_dat1 (head1),
    .count   (count)
  );

  // A lone lane-1 request takes the head entry, not head+1.
  assign alloc_prd_first_o  = head0;
  assign alloc_prd_second_o = req_first_i ? head1 : head0;
  assign stage_cnt_o        = count;

`ifdef PREG_ALLOC_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Survives flushes on purpose: it measures starvation over the whole run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((need != '0) && !alloc_ready_o && !flush_i) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_rcu_preg_alloc.sv
// Self-checking bench for rcu_preg_alloc against a queue-level model of staging and free list.
// Latency: one model step per clock; outputs sampled on the falling edge.
// Backpressure: rename requests are held until granted, as the allocator requires.
module tb_rcu_preg_alloc;
  import rcu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic                       flush_i;
  logic                       req_first_i;
  logic                       req_second_i;
  logic                       alloc_ready_o;
  logic [PREG_WIDTH-1:0]      alloc_prd_first_o;
  logic [PREG_WIDTH-1:0]      alloc_prd_second_o;
  logic                       fl_rd_first_en_o;
  logic                       fl_rd_second_en_o;
  logic [PREG_WIDTH-1:0]      fl_rdata_first_i;
  logic [PREG_WIDTH-1:0]      fl_rdata_second_i;
  logic                       fl_empty_i;
  logic                       fl_almost_empty_i;
  logic [STAGE_DEPTH_WIDTH:0] stage_cnt_o;
`ifdef PREG_ALLOC_STALL_CNT_EN
  logic [31:0]                stall_cnt_o;
`endif

  rcu_preg_alloc dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .req_first_i        (req_first_i),
    .req_second_i       (req_second_i),
    .alloc_ready_o      (alloc_ready_o),
    .alloc_prd_first_o  (alloc_prd_first_o),
    .alloc_prd_second_o (alloc_prd_second_o),
    .fl_rd_first_en_o   (fl_rd_first_en_o),
    .fl_rd_second_en_o  (fl_rd_second_en_o),
    .fl_rdata_first_i   (fl_rdata_first_i),
    .fl_rdata_second_i  (fl_rdata_second_i),
    .fl_empty_i         (fl_empty_i),
    .fl_almost_empty_i  (fl_almost_empty_i),
    .stage_cnt_o        (stage_cnt_o)
`ifdef PREG_ALLOC_STALL_CNT_EN
    ,
    .stall_cnt_o        (stall_cnt_o)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  int   fl_q[$];      // free-list contents, head first
  int   stage_q[$];   // staged tags in hand-out order
  int   retire_q[$];  // granted tags waiting to be freed again
  int   stall_exp = 0;
  logic recycle = 1'b0;
  logic pending = 1'b0;
  logic cur_r0 = 1'b0;
  logic cur_r1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic fill_fl();
    fl_q.delete();
    for (int t = 1; t <= 31; t++) fl_q.push_back(t);
  endtask

  task automatic drive_fl();
    fl_empty_i        = (fl_q.size() == 0);
    fl_almost_empty_i = (fl_q.size() < 2);
    fl_rdata_first_i  = (fl_q.size() > 0) ? PREG_WIDTH'(fl_q[0]) : '0;
    fl_rdata_second_i = (fl_q.size() > 1) ? PREG_WIDTH'(fl_q[1]) : '0;
  endtask

  task automatic model_reset();
    stage_q.delete();
    retire_q.delete();
    fill_fl();
    stall_exp = 0;
    pending   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, alloc_ready_o, 0);
    check({tag, "_pop0"}, fl_rd_first_en_o, 0);
    check({tag, "_pop1"}, fl_rd_second_en_o, 0);
    check({tag, "_cnt"}, stage_cnt_o, 0);
    check({tag, "_prd0"}, alloc_prd_first_o, 0);
    check({tag, "_prd1"}, alloc_prd_second_o, 0);
`ifdef PREG_ALLOC_STALL_CNT_EN
    check({tag, "_stall"}, stall_cnt_o, 0);
`endif
  endtask

  // One clock: apply inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic f, input logic r0, input logic r1);
    int   need;
    int   cnt;
    int   free_n;
    logic e_rdy;
    logic e_p0;
    logic e_p1;
    logic gnt;
    flush_i      = f;
    req_first_i  = r0;
    req_second_i = r1;
    drive_fl();
    @(negedge clk);
    need   = int'(r0) + int'(r1);
    cnt    = stage_q.size();
    free_n = STAGE_DEPTH - cnt;
    e_rdy  = !f && (cnt >= need);
    gnt    = e_rdy && (need > 0);
    e_p0   = !f && (free_n >= 1) && (fl_q.size() >= 1);
    e_p1   = e_p0 && (free_n >= 2) && (fl_q.size() >= 2);
    check("stage_cnt", stage_cnt_o, cnt);
    check("ready", alloc_ready_o, e_rdy);
    check("pop0", fl_rd_first_en_o, e_p0);
    check("pop1", fl_rd_second_en_o, e_p1);
    if (gnt && r0) check("prd_first", alloc_prd_first_o, stage_q[0]);
    if (gnt && r1) check("prd_second", alloc_prd_second_o, r0 ? stage_q[1] : stage_q[0]);
`ifdef PREG_ALLOC_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, stall_exp);
`endif
    if ((need > 0) && !e_rdy && !f) stall_exp++;
    pending = (need > 0) && !gnt && !f;
    @(posedge clk);
    if (f) begin
      // The free list rewinds: discarded staged tags become available again.
      for (int i = stage_q.size() - 1; i >= 0; i--) fl_q.push_front(stage_q[i]);
      stage_q.delete();
    end else begin
      if (gnt) repeat (need) retire_q.push_back(stage_q.pop_front());
      if (e_p0) stage_q.push_back(fl_q.pop_front());
      if (e_p1) stage_q.push_back(fl_q.pop_front());
    end
    if (recycle && (retire_q.size() > 0) && ($urandom_range(1, 0) == 1))
      fl_q.push_back(retire_q.pop_front());
    #1;
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; req_first_i = 1'b0; req_second_i = 1'b0;
    model_reset();
    drive_fl();
    #3;
    check_all_zero("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold start: two pops per cycle until four tags are staged.
    cycle(0, 0, 0);
    check("warm_cnt2", stage_cnt_o, 2);
    cycle(0, 0, 0);
    check("warm_cnt4", stage_cnt_o, 4);
    cycle(0, 0, 0);
    check("warm_head", alloc_prd_first_o, 1);

    // Dual grant from a full buffer, then a lone lane-1 grant.
    cycle(0, 1, 1);
    check("dual_cnt", stage_cnt_o, 2);
    check("dual_head", alloc_prd_first_o, 3);
    cycle(0, 0, 1);
    check("lane1_cnt", stage_cnt_o, 3);

    // Nearly empty free list with an empty buffer.
    cycle(1, 0, 0);
    check("flush_cnt", stage_cnt_o, 0);
    fl_q.delete();
    fl_q.push_back(9);
    cycle(0, 1, 1);
    check("single_pop_cnt", stage_cnt_o, 1);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    check("single_grant_cnt", stage_cnt_o, 0);

    // Flush with three staged tags and both lanes requesting.
    fl_q.delete();
    fl_q.push_back(20); fl_q.push_back(21); fl_q.push_back(22);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("pre_flush_cnt", stage_cnt_o, 3);
    cycle(1, 1, 1);
    check("post_flush_cnt", stage_cnt_o, 0);
    cycle(0, 0, 0);
    check("resume_cnt", stage_cnt_o, 2);

    // Reset mid-operation must clear outputs without a clock edge.
    req_first_i = 1'b1; req_second_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Starve both lanes for five cycles.
    fl_q.delete();
    repeat (5) cycle(0, 1, 1);
`ifdef PREG_ALLOC_STALL_CNT_EN
    check("stall_five", stall_cnt_o, 5);
`endif

    // Random traffic with tags recycled back to the free list.
    fill_fl();
    recycle = 1'b1;
    for (int k = 0; k < 600; k++) begin
      logic f;
      f = ($urandom_range(31, 0) == 0);
      if (!pending) begin
        cur_r0 = $urandom_range(1, 0);
        cur_r1 = $urandom_range(1, 0);
      end
      cycle(f, cur_r0, cur_r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
